// File: rtl/zmod_pkg.sv
// Shared types and constants for the zmod receive framing logic.
package zmod_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  localparam int unsigned ERR_W = 16;

endpackage

// File: rtl/zmod_align_window.sv
// Rotate-select of one lane: picks WIDTH bits from {prev, cur} starting at bit s.
module zmod_align_window #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SW = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] pair,
  input  logic [SW-1:0]      s,
  output logic [WIDTH-1:0]   win_c
);

  assign win_c = WIDTH'(pair >> s);

endmodule

// File: rtl/zmod_frame_aligner.sv
// Receive-side frame aligner: hunts the sync rotation, qualifies lock with
// hysteresis and emits bit-aligned data words with error accounting.
module zmod_frame_aligner
  import zmod_pkg::*;
#(
  parameter int unsigned LANES      = 3,
  parameter int unsigned WIDTH      = 8,
  parameter logic [7:0]  SYNC_WORD  = 8'b0000_0001,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_sync,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     realign,
  output logic                     out_valid,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     out_err,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] shift,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MW = $clog2(LOSS_COUNT + 1);
  localparam logic [WIDTH-1:0] SYNC = SYNC_WORD[WIDTH-1:0];

  align_state_t     state, state_d;
  logic [WIDTH-1:0] prev_sync, prev_sync_d;
  logic [DW-1:0]    prev_data, prev_data_d;
  logic             have_prev, have_prev_d;
  logic [SW-1:0]    shift_d;
  logic [GW-1:0]    good_cnt, good_cnt_d;
  logic [MW-1:0]    miss_cnt, miss_cnt_d;
  logic [ERR_W-1:0] err_count_d;
  logic             out_valid_d, out_err_d, locked_d;
  logic [DW-1:0]    out_data_d;

  logic [WIDTH-1:0] match;
  logic [SW-1:0]    cand;
  logic             hit;
  logic [DW-1:0]    data_win;
  logic             evaluate;

  // Sync lane: one comparator per candidate rotation.
  for (genvar gs = 0; gs < WIDTH; gs++) begin : g_match
    logic [WIDTH-1:0] sync_win;
    zmod_align_window #(.WIDTH(WIDTH)) u_sync_win (
      .pair  ({prev_sync, in_sync}),
      .s     (SW'(gs)),
      .win_c (sync_win)
    );
    assign match[gs] = (sync_win == SYNC);
  end

  // Data lanes follow the latched rotation.
  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    zmod_align_window #(.WIDTH(WIDTH)) u_data_win (
      .pair  ({prev_data[gl*WIDTH +: WIDTH], in_data[gl*WIDTH +: WIDTH]}),
      .s     (shift),
      .win_c (data_win[gl*WIDTH +: WIDTH])
    );
  end

  assign evaluate = in_valid && have_prev && !realign;

  // Lowest matching rotation wins.
  always_comb begin
    cand = '0;
    hit  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        cand = SW'(i);
        hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      prev_sync <= '0;
      prev_data <= '0;
      have_prev <= 1'b0;
      shift     <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      err_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      prev_sync <= prev_sync_d;
      prev_data <= prev_data_d;
      have_prev <= have_prev_d;
      shift     <= shift_d;
      good_cnt  <= good_cnt_d;
      miss_cnt  <= miss_cnt_d;
      err_count <= err_count_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_err   <= out_err_d;
      locked    <= locked_d;
    end
  end

  always_comb begin
    state_d     = state;
    prev_sync_d = prev_sync;
    prev_data_d = prev_data;
    have_prev_d = have_prev;
    shift_d     = shift;
    good_cnt_d  = good_cnt;
    miss_cnt_d  = miss_cnt;
    err_count_d = err_count;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    out_err_d   = 1'b0;

    if (in_valid) begin
      prev_sync_d = in_sync;
      prev_data_d = in_data;
      have_prev_d = 1'b1;
    end

    // realign pre-empts evaluation of any beat in the same cycle.
    if (realign) begin
      state_d    = HUNT;
      good_cnt_d = '0;
      miss_cnt_d = '0;
    end else if (evaluate) begin
      unique case (state)
        HUNT: begin
          if (hit) begin
            shift_d    = cand;
            good_cnt_d = GW'(1);
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (match[shift]) begin
            good_cnt_d = GW'(good_cnt + GW'(1));
            if (good_cnt_d == GW'(LOCK_COUNT)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            state_d    = HUNT;
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          out_valid_d = 1'b1;
          out_data_d  = data_win;
          if (match[shift]) begin
            miss_cnt_d = '0;
          end else begin
            out_err_d = 1'b1;
            if (err_count != '1) begin
              err_count_d = err_count + ERR_W'(1);
            end
            miss_cnt_d = MW'(miss_cnt + MW'(1));
            if (miss_cnt_d == MW'(LOSS_COUNT)) begin
              state_d    = HUNT;
              miss_cnt_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

endmodule

// File: tb/tb_zmod_frame_aligner.sv
// Self-checking bench for zmod_frame_aligner: directed phases with random data,
// checked every beat against a per-beat behavioural model.
module tb_zmod_frame_aligner;

  localparam int LANES = 3;
  localparam int LOCK  = 16;
  localparam int LOSS  = 4;
  localparam int SYNC  = 1;
  localparam int NG    = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, realign, out_valid, out_err, locked;
  logic [7:0]  in_sync;
  logic [23:0] in_data, out_data;
  logic [2:0]  shift;
  logic [15:0] err_count;

  logic        sat_valid, sat_realign, sat_out_valid, sat_out_err, sat_locked;
  logic [7:0]  sat_sync;
  logic [23:0] sat_data, sat_out_data;
  logic [2:0]  sat_shift;
  logic [15:0] sat_err;

  int checks = 0;
  int errors = 0;

  zmod_frame_aligner dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
    .in_data(in_data), .realign(realign), .out_valid(out_valid),
    .out_data(out_data), .out_err(out_err), .locked(locked),
    .shift(shift), .err_count(err_count)
  );

  // Long loss window so saturation is reachable while staying locked.
  zmod_frame_aligner #(.LOSS_COUNT(1000)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(sat_valid), .in_sync(sat_sync),
    .in_data(sat_data), .realign(sat_realign), .out_valid(sat_out_valid),
    .out_data(sat_out_data), .out_err(sat_out_err), .locked(sat_locked),
    .shift(sat_shift), .err_count(sat_err)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int          m_st, m_shift, m_good, m_miss, m_err, m_have, m_psync;
  int          m_pdata[LANES];
  int          e_valid, e_err, e_locked;
  logic [23:0] e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int win(input int p, input int c, input int s);
    return (((p << 8) | c) >> s) & 255;
  endfunction

  // Raw lane words whose rotation-r window reproduces counter value c.
  function automatic logic [23:0] raw_data(input logic [23:0] c, input int r);
    logic [23:0] n, res;
    int a, b;
    n = c + 24'd1;
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      a = int'(c[l*8 +: 8]);
      b = int'(n[l*8 +: 8]);
      res[l*8 +: 8] = 8'(((a << r) | (b >> (8 - r))) & 255);
    end
    return res;
  endfunction

  task automatic model_reset();
    m_st = 0; m_shift = 0; m_good = 0; m_miss = 0; m_err = 0; m_have = 0; m_psync = 0;
    for (int l = 0; l < LANES; l++) m_pdata[l] = 0;
    e_valid = 0; e_err = 0; e_locked = 0; e_data = '0;
  endtask

  // States: 0 hunt, 1 verify, 2 locked.
  task automatic model_beat(input bit v, input int sync, input logic [23:0] data, input bit rl);
    bit mt[8];
    bit hit;
    int cand;
    e_valid = 0;
    e_err   = 0;
    if (rl) begin
      m_st = 0; m_good = 0; m_miss = 0;
    end else if (v && m_have != 0) begin
      hit = 0; cand = 0;
      for (int s = 7; s >= 0; s--) begin
        mt[s] = (win(m_psync, sync, s) == SYNC);
        if (mt[s]) begin hit = 1; cand = s; end
      end
      case (m_st)
        0: if (hit) begin m_shift = cand; m_good = 1; m_st = 1; end
        1: begin
          if (mt[m_shift]) begin
            m_good++;
            if (m_good == LOCK) begin m_st = 2; m_miss = 0; end
          end else begin
            m_st = 0; m_good = 0;
          end
        end
        default: begin
          e_valid = 1;
          for (int l = 0; l < LANES; l++)
            e_data[l*8 +: 8] = 8'(win(m_pdata[l], int'(data[l*8 +: 8]), m_shift));
          if (mt[m_shift]) m_miss = 0;
          else begin
            e_err = 1;
            if (m_err < 65535) m_err++;
            m_miss++;
            if (m_miss == LOSS) begin m_st = 0; m_miss = 0; end
          end
        end
      endcase
    end
    if (v) begin
      m_psync = sync;
      for (int l = 0; l < LANES; l++) m_pdata[l] = int'(data[l*8 +: 8]);
      m_have = 1;
    end
    e_locked = (m_st == 2) ? 1 : 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("locked",    64'(locked),    64'(e_locked));
    chk("shift",     64'(shift),     64'(m_shift));
    chk("err_count", 64'(err_count), 64'(m_err));
    if (e_valid != 0) begin
      chk("out_data", 64'(out_data), 64'(e_data));
      chk("out_err",  64'(out_err),  64'(e_err));
    end
  endtask

  task automatic step(input bit v, input int sync, input logic [23:0] data, input bit rl);
    in_valid = v; in_sync = 8'(sync); in_data = data; realign = rl;
    @(posedge clk);
    model_beat(v, sync, data, rl);
    #1;
    check_outputs();
    in_valid = 1'b0; realign = 1'b0;
  endtask

  task automatic sat_beat(input logic [7:0] sy);
    sat_sync = sy; sat_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] cnt;
    int R;
    int gs[NG+1];
    logic [23:0] gd[NG+1];
    logic [31:0] qa[$], qb[$];

    rst_n = 1'b0; in_valid = 1'b0; in_sync = '0; in_data = '0; realign = 1'b0;
    sat_valid = 1'b0; sat_sync = '0; sat_data = '0; sat_realign = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_locked",    64'(locked),    64'(0));
    chk("rst_shift",     64'(shift),     64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Lock at rotation 0 with a counter on the data lanes.
    cnt = 24'd0;
    for (int k = 1; k <= 22; k++) begin
      step(1'b1, SYNC, cnt, 1'b0);
      if (k == 16) chk("lock_b16", 64'(locked), 64'(0));
      if (k == 17) begin
        chk("lock_b17", 64'(locked), 64'(1));
        chk("lock_shift0", 64'(shift), 64'(0));
      end
      if (k >= 18) begin
        chk("cnt_data", 64'(out_data), 64'(cnt));
        chk("cnt_err", 64'(out_err), 64'(0));
      end
      cnt++;
    end

    // Every rotation, with pre-rotated data lanes.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 20; k++) begin
        step(1'b1, 1 << r, raw_data(cnt, r), k == 0);
        cnt++;
      end
      chk("rot_shift", 64'(shift), 64'(r));
      chk("rot_locked", 64'(locked), 64'(1));
      if (r == 3) begin
        for (int k = 0; k < 4; k++) begin
          step(1'b1, 1 << r, raw_data(cnt, r), 1'b0);
          chk("rot_data", 64'(out_data), 64'(cnt));
          cnt++;
        end
      end
    end
    R = 7;

    // Loss hysteresis.
    for (int j = 0; j < 3; j++) begin step(1'b1, 0, raw_data(cnt, R), 1'b0); cnt++; end
    step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++;
    chk("loss_hold_locked", 64'(locked), 64'(1));
    chk("loss_hold_err", 64'(err_count), 64'(3));
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 0, raw_data(cnt, R), 1'b0); cnt++;
      if (j == 2) chk("loss_3rd_locked", 64'(locked), 64'(1));
    end
    chk("loss_drop_locked", 64'(locked), 64'(0));
    chk("loss_drop_err", 64'(err_count), 64'(7));

    // VERIFY abort.
    for (int j = 0; j < 10; j++) begin step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++; end
    step(1'b1, 0, raw_data(cnt, R), 1'b0); cnt++;
    chk("abort_locked", 64'(locked), 64'(0));
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++;
      if (j == 15) chk("abort_15", 64'(locked), 64'(0));
    end
    chk("abort_relock", 64'(locked), 64'(1));

    // realign together with a valid beat.
    step(1'b1, 1 << R, raw_data(cnt, R), 1'b1); cnt++;
    chk("realign_locked", 64'(locked), 64'(0));
    chk("realign_err", 64'(err_count), 64'(7));
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++;
      if (j == 15) chk("realign_15", 64'(locked), 64'(0));
    end
    chk("realign_relock", 64'(locked), 64'(1));

    // Same beat list with and without gaps must give the same outputs.
    for (int i = 0; i <= NG; i++) begin
      gs[i] = (i > 20 && $urandom_range(0, 4) == 0) ? 0 : (1 << R);
      gd[i] = 24'($urandom());
    end
    step(1'b1, gs[0], gd[0], 1'b1);
    for (int i = 1; i <= NG; i++) begin
      step(1'b1, gs[i], gd[i], 1'b0);
      if (e_valid != 0) qa.push_back({7'd0, 1'(e_err), e_data});
    end
    step(1'b1, gs[0], gd[0], 1'b1);
    for (int i = 1; i <= NG; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, int'($urandom_range(0, 255)), 24'($urandom()), 1'b0);
      step(1'b1, gs[i], gd[i], 1'b0);
      if (out_valid) qb.push_back({7'd0, out_err, out_data});
    end
    chk("gap_len", 64'(qb.size()), 64'(qa.size()));
    for (int i = 0; i < qa.size() && i < qb.size(); i++) chk("gap_seq", 64'(qb[i]), 64'(qa[i]));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 99) < 85) ? (1 << R) : int'($urandom_range(0, 255)),
           24'($urandom()), $urandom_range(0, 63) == 0);
    end

    // Asynchronous reset while locked.
    for (int i = 0; i < 40 && e_locked == 0; i++) begin
      step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++;
    end
    for (int i = 0; i < 3; i++) begin step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++; end
    chk("pre_rst_locked", 64'(locked), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_data",  64'(out_data),  64'(0));
    chk("arst_out_err",   64'(out_err),   64'(0));
    chk("arst_locked",    64'(locked),    64'(0));
    chk("arst_shift",     64'(shift),     64'(0));
    chk("arst_err_count", 64'(err_count), 64'(0));
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin step(1'b1, 1 << R, raw_data(cnt, R), 1'b0); cnt++; end
    chk("post_rst_lock", 64'(locked), 64'(1));

    // Error counter saturation.
    for (int k = 0; k < 17; k++) sat_beat(8'h01);
    chk("sat_locked_start", 64'(sat_locked), 64'(1));
    for (int b = 0; b < 66; b++) begin
      for (int j = 0; j < 999; j++) sat_beat(8'h00);
      sat_beat(8'h01);
      if (b == 0) chk("sat_err_first", 64'(sat_err), 64'(999));
      if (b == 64) chk("sat_err_pre", 64'(sat_err), 64'(64935));
    end
    chk("sat_err_final", 64'(sat_err), 64'(16'hFFFF));
    chk("sat_locked_end", 64'(sat_locked), 64'(1));
    sat_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
